// File: rtl/adc_pkg.sv
// Shared definitions for the LTC2308 scan controller: FSM state encoding,
// channel-to-mux-code table, frame constants and small channel-walk helpers.
package adc_pkg;

    localparam int DATA_BITS = 12;  // conversion result width
    localparam int CMD_BITS  = 6;   // config word width on SDI
    localparam int T_WHCONV  = 3;   // CONVST high time in clk cycles

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVST,
        S_CONV,
        S_XFER,
        S_ACQ,
        S_STORE
    } state_e;

    // Single-ended channel index -> {O/S, S1, S0}
    localparam logic [2:0] CH_CODE [8] = '{
        3'b000, 3'b100, 3'b001, 3'b101,
        3'b010, 3'b110, 3'b011, 3'b111
    };

    // Config word {S/D=1, O/S, S1, S0, UNI, SLP=0}, shifted MSB first.
    function automatic logic [CMD_BITS-1:0] cfg_word(input logic [2:0] ch,
                                                      input logic       uni);
        return {1'b1, CH_CODE[ch], uni, 1'b0};
    endfunction

    // Next enabled channel strictly after cur, wrapping to the lowest one.
    // Passing cur = 7 yields the lowest enabled channel.
    function automatic logic [2:0] next_ch(input logic [7:0] mask,
                                           input logic [2:0] cur);
        logic [2:0] res;
        logic [2:0] idx;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = cur + 3'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // True when no enabled channel lies above ch.
    function automatic logic is_last(input logic [7:0] mask,
                                     input logic [2:0] ch);
        logic res;
        res = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) > ch && mask[i]) res = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/adc_ltc2308_shift.sv
// One LTC2308 serial frame: 12 SCK pulses, config word out on SDI while SCK
// is low, result in from SDO on each SCK rising edge. start/done handshake.
module adc_ltc2308_shift
    import adc_pkg::*;
#(
    parameter int SCK_HALF = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [CMD_BITS-1:0]  cmd,
    input  logic                 sdo,
    output logic                 sck,
    output logic                 sdi,
    output logic                 done,
    output logic [DATA_BITS-1:0] data
);

    localparam int PH_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

    logic                 active;
    logic [PH_W-1:0]      phase;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] tx;

    // SDI follows the transmit register, which only moves on SCK falling
    // edges, so SDI never changes while SCK is high.
    assign sdi = tx[DATA_BITS-1];

    // Half-period timer driving SCK; sample SDO on rise, advance SDI on fall.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: every register here is state, so <= keeps all updates
        // simultaneous at the clock edge regardless of statement order.
        if (!reset_n) begin
            active  <= 1'b0;
            sck     <= 1'b0;
            done    <= 1'b0;
            phase   <= '0;
            bit_cnt <= '0;
            tx      <= '0;
            data    <= '0;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (start) begin
                    active  <= 1'b1;
                    sck     <= 1'b0;
                    phase   <= '0;
                    bit_cnt <= '0;
                    tx      <= {cmd, {(DATA_BITS-CMD_BITS){1'b0}}};
                end
            end else if (phase != PH_W'(SCK_HALF - 1)) begin
                phase <= phase + 1'b1;
            end else begin
                phase <= '0;
                if (!sck) begin
                    sck  <= 1'b1;
                    data <= {data[DATA_BITS-2:0], sdo};
                end else begin
                    sck <= 1'b0;
                    if (bit_cnt == 4'(DATA_BITS - 1)) begin
                        active <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        tx      <= tx << 1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/adc_ltc2308_scan.sv
// LTC2308 multi-channel scan controller. Walks the enabled channels in
// ascending order using the ADC's one-frame config pipeline: a priming frame
// sends the first channel's config, every later frame stores the previous
// channel's result. Results are readable at any time through rd_ch/rd_data.
// Optional build macro ADC_LTC2308_AVG_EN: each result becomes the running
// mean of the last 4 samples of its channel.
module adc_ltc2308_scan
    import adc_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int T_CONV   = 64,
    parameter int T_ACQ    = 320,
    parameter int SCK_HALF = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [NUM_CH-1:0]    ch_mask,
    input  logic                 uni,
    output logic                 busy,
    output logic                 scan_done,
    input  logic [2:0]           rd_ch,
    output logic [DATA_BITS-1:0] rd_data,
    output logic [NUM_CH-1:0]    valid,
    output logic                 ADC_CONVST,
    output logic                 ADC_SCK,
    output logic                 ADC_SDI,
    input  logic                 ADC_SDO
);

    localparam int CNT_MAX = (T_ACQ > T_CONV) ? T_ACQ : T_CONV;
    localparam int CNT_W   = $clog2(CNT_MAX + T_WHCONV + 1);

    state_e               state;
    logic [CNT_W-1:0]     cnt;
    logic                 start_d;
    logic [7:0]           mask_pad;
    logic [7:0]           mask_q;
    logic                 uni_q;
    logic [2:0]           send_ch;   // channel whose config goes out this frame
    logic [2:0]           store_ch;  // channel whose data arrives this frame
    logic                 priming;
    logic                 shift_start;
    logic                 shift_done;
    logic [DATA_BITS-1:0] shift_data;
    logic                 store_en;
    logic [DATA_BITS-1:0] results [NUM_CH];

    // Widen the live mask to 8 bits so the channel helpers see one shape.
    always_comb begin
        mask_pad             = '0;
        mask_pad[NUM_CH-1:0] = ch_mask;
    end

    assign busy       = (state != S_IDLE);
    assign ADC_CONVST = (state == S_CONVST);
    assign store_en   = (state == S_STORE) && !priming;

    adc_ltc2308_shift #(
        .SCK_HALF (SCK_HALF)
    ) u_shift (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (shift_start),
        .cmd     (cfg_word(send_ch, uni_q)),
        .sdo     (ADC_SDO),
        .sck     (ADC_SCK),
        .sdi     (ADC_SDI),
        .done    (shift_done),
        .data    (shift_data)
    );

    // Frame sequencer and channel walk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            start_d     <= 1'b0;
            mask_q      <= '0;
            uni_q       <= 1'b0;
            send_ch     <= '0;
            store_ch    <= '0;
            priming     <= 1'b0;
            shift_start <= 1'b0;
            scan_done   <= 1'b0;
        end else begin
            start_d     <= start;
            shift_start <= 1'b0;
            scan_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !start_d && (mask_pad != '0)) begin
                        mask_q  <= mask_pad;
                        uni_q   <= uni;
                        send_ch <= next_ch(mask_pad, 3'd7);
                        priming <= 1'b1;
                        cnt     <= '0;
                        state   <= S_CONVST;
                    end
                end
                S_CONVST: begin
                    if (cnt == CNT_W'(T_WHCONV - 1)) begin
                        cnt   <= '0;
                        state <= S_CONV;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CONV: begin
                    if (cnt == CNT_W'(T_CONV - 1)) begin
                        cnt         <= '0;
                        shift_start <= 1'b1;
                        state       <= S_XFER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_XFER: begin
                    if (shift_done) begin
                        cnt   <= '0;
                        state <= S_ACQ;
                    end
                end
                S_ACQ: begin
                    if (cnt == CNT_W'(T_ACQ - 1)) begin
                        cnt   <= '0;
                        state <= S_STORE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STORE: begin
                    cnt <= '0;
                    if (priming || !is_last(mask_q, store_ch)) begin
                        priming  <= 1'b0;
                        store_ch <= send_ch;
                        send_ch  <= next_ch(mask_q, send_ch);
                        state    <= S_CONVST;
                    end else begin
                        scan_done <= 1'b1;
                        if (continuous && (mask_pad != '0)) begin
                            mask_q  <= mask_pad;
                            uni_q   <= uni;
                            send_ch <= next_ch(mask_pad, 3'd7);
                            priming <= 1'b1;
                            state   <= S_CONVST;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ADC_LTC2308_AVG_EN
    logic [13:0]          acc   [NUM_CH];
    logic [1:0]           wp    [NUM_CH];
    logic [2:0]           nsamp [NUM_CH];
    logic [DATA_BITS-1:0] hist  [NUM_CH][4];
    logic [13:0]          acc_sel;
    logic [13:0]          acc_next;
    logic [DATA_BITS-1:0] old_sel;
    logic [1:0]           wp_sel;
    logic [2:0]           nsamp_sel;

    // Sliding 4-sample window update for the channel being stored.
    always_comb begin
        acc_sel   = '0;
        old_sel   = '0;
        wp_sel    = '0;
        nsamp_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (store_ch == 3'(i)) begin
                acc_sel   = acc[i];
                wp_sel    = wp[i];
                nsamp_sel = nsamp[i];
                // Subtract the oldest sample only once the window is full,
                // so the history buffer never needs clearing.
                old_sel   = (nsamp[i] == 3'd4) ? hist[i][wp[i]] : '0;
            end
        end
        acc_next = acc_sel + 14'(shift_data) - 14'(old_sel);
    end

    // Accumulators, counters and the stored mean (raw until 4 samples seen).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the result array is reset because reads of channels that
            // were never stored must return 0; the history buffer is not.
            for (int i = 0; i < NUM_CH; i++) begin
                results[i] <= '0;
                acc[i]     <= '0;
                wp[i]      <= '0;
                nsamp[i]   <= '0;
            end
            valid <= '0;
        end else if (store_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (store_ch == 3'(i)) begin
                    acc[i]   <= acc_next;
                    wp[i]    <= wp_sel + 1'b1;
                    nsamp[i] <= (nsamp_sel == 3'd4) ? 3'd4 : nsamp_sel + 1'b1;
                    if (nsamp_sel >= 3'd3) begin
                        results[i] <= acc_next[13:2];
                        valid[i]   <= 1'b1;
                    end else begin
                        results[i] <= shift_data;
                    end
                end
            end
        end
    end

    // Sample history ring; contents are ignored until the window is full.
    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (store_ch == 3'(i)) hist[i][wp_sel] <= shift_data;
            end
        end
    end
`else
    // Store the raw word for the channel configured one frame earlier.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the result array is reset because reads of channels that
            // were never stored must return 0.
            for (int i = 0; i < NUM_CH; i++) results[i] <= '0;
            valid <= '0;
        end else if (store_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (store_ch == 3'(i)) begin
                    results[i] <= shift_data;
                    valid[i]   <= 1'b1;
                end
            end
        end
    end
`endif

    // Combinational readback; out-of-range channels read as 0.
    always_comb begin
        // NOTE: default first so every path assigns rd_data and no latch forms.
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == 3'(i)) rd_data = results[i];
        end
    end

endmodule

// File: doc/adc_ltc2308_scan.md
ADC_LTC2308_SCAN -- requirements
Module: adc_ltc2308_scan

Interface
REQ-001 Parameter NUM_CH, default 8: number of scanned channels, 1..8.
REQ-002 Parameter T_CONV, default 64: conversion wait in clk cycles; covers the 1.6 us maximum at 40 MHz.
REQ-003 Parameter T_ACQ, default 320: acquisition hold in clk cycles after each frame.
REQ-004 Parameter SCK_HALF, default 1: ADC_SCK half-period in clk cycles, minimum 1.
REQ-005 clk  in  1  system clock, at most 40 MHz.
REQ-006 reset_n  in  1  reset; one clock; asynchronous, active-low.
REQ-007 start  in  1  rising edge begins a scan.
REQ-008 continuous  in  1  1 restarts the scan after scan_done; 0 runs a single scan.
REQ-009 ch_mask  in  NUM_CH  enabled channels; sampled at scan start.
REQ-010 uni  in  1  1 selects unipolar, 0 selects bipolar; sampled at scan start.
REQ-011 busy  out  1  high while a scan is in progress.
REQ-012 scan_done  out  1  one-cycle pulse after the last enabled channel is stored.
REQ-013 rd_ch  in  3  result readback channel select.
REQ-014 rd_data  out  12  result for rd_ch; combinational read.
REQ-015 valid  out  NUM_CH  per-channel result-present flags.
REQ-016 ADC_CONVST, ADC_SCK, ADC_SDI  out  1  ADC control pins.
REQ-017 ADC_SDO  in  1  ADC serial data.

Function
REQ-018 FSM states: IDLE, CONVST, CONV, XFER, ACQ, STORE.
REQ-019 IDLE: a start rising edge with a nonzero ch_mask latches ch_mask and uni, then moves to CONVST.
REQ-020 A start edge with ch_mask == 0 is ignored; busy stays low.
REQ-021 CONVST: ADC_CONVST is high for exactly 3 clk cycles, then the FSM moves to CONV.
REQ-022 CONV: the FSM waits T_CONV cycles with ADC_SCK low, then moves to XFER.
REQ-023 XFER: exactly 12 ADC_SCK pulses are generated; ADC_SCK idles low.
REQ-024 XFER: ADC_SDO is sampled on each ADC_SCK rising edge, MSB first.
REQ-025 XFER: a 6-bit config word {S/D=1, O/S, S1, S0, uni, SLP=0} is driven on ADC_SDI during the first 6 SCK periods, MSB first; ADC_SDI is changed only while ADC_SCK is low.
REQ-026 XFER: ADC_SDI is 0 after the config word has been sent.
REQ-027 Channel-to-code mapping: ch0..7 map to {O/S,S1,S0} codes 000, 100, 001, 101, 010, 110, 011, 111.
REQ-028 Pipelining: the config sent in frame k applies to frame k+1.
REQ-029 The first frame of every scan is a priming frame; its data is discarded.
REQ-030 Each subsequent frame stores the result for the channel configured in the previous frame and sends the next enabled channel's config.
REQ-031 A scan with E enabled channels takes E+1 frames.
REQ-032 ACQ: the FSM waits T_ACQ cycles, then moves to STORE.
REQ-033 STORE: the captured word is written to the result entry, the valid bit is set, then the FSM moves to CONVST or ends the scan.
REQ-034 Enabled channels are visited in ascending index order; disabled channels are skipped without a frame.
REQ-035 The last frame of a scan sends the config of the lowest enabled channel; it is harmless.
REQ-036 At scan end scan_done pulses for 1 cycle.
REQ-037 With continuous=1 at scan end, a new scan begins on the next cycle using freshly sampled ch_mask and uni, starting with a new priming frame.
REQ-038 With continuous=0 at scan end, the FSM returns to IDLE and busy falls.
REQ-039 A start edge while busy is ignored.
REQ-040 Results are retained across scans; valid bits are never cleared except by reset.
REQ-041 A rd_ch value >= NUM_CH returns 0.

Reset
REQ-042 reset_n low forces the FSM to IDLE immediately.
REQ-043 During reset, ADC_CONVST, ADC_SCK, ADC_SDI, busy, scan_done and valid are 0; all results are 0.
REQ-044 An assertion mid-frame aborts the frame; a later start begins with a priming frame.

Configuration
REQ-045 Macro ADC_LTC2308_AVG_EN defined: each stored result is the mean of the last 4 samples of that channel, computed as a 14-bit per-channel accumulator >> 2.
REQ-046 With ADC_LTC2308_AVG_EN, valid is set only after 4 samples of that channel; until then rd_data returns the raw latest sample.
REQ-047 Macro undefined: the raw sample is stored; there are no accumulators.

Structure
REQ-048 Shared package adc_pkg holds the FSM state enum, the channel-code lookup table, DATA_BITS=12, CMD_BITS=6 and T_WHCONV=3.
REQ-049 One sub-module, adc_ltc2308_shift, performs SCK generation and the 12-bit SDI/SDO shift; it has a start/done handshake.

Verification
REQ-050 Test: ch_mask=8'b00000101, single scan, SDO model returning channel-code-derived data -> 3 frames; ch0 and ch2 results correct; valid=0x05; one scan_done pulse.
REQ-051 Test: uni=1, ch3 -> SDI config word observed as 6'b110110 on the wire.
REQ-052 Test: continuous=1 with ch_mask changed mid-scan -> the current scan completes unchanged; the next scan uses the new mask and starts with a priming frame.
REQ-053 Test: reset_n pulsed during XFER -> outputs 0 within the same cycle; a restart produces a correct scan.
REQ-054 Test: start with ch_mask=0, and start asserted while busy -> no activity and no change to the running scan, respectively.
REQ-055 Test: ADC_LTC2308_AVG_EN with samples 100, 200, 300, 400 -> rd_data=250, valid set after the 4th sample.
